// File: rtl/floating_point_adder.sv
// floating_point_adder: IEEE-754 single-precision A+B, one combinational path into one output register.
// Define FPADD_ROUND_NEAREST_EN for round-to-nearest-ties-to-even; by default the result is truncated.
module floating_point_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic [31:0] result
);

`ifdef FPADD_ROUND_NEAREST_EN
    localparam logic RoundNearest = 1'b1;
`else
    localparam logic RoundNearest = 1'b0;
`endif

    localparam logic [31:0] QuietNan = 32'h7FC00000;

    logic        signA;
    logic        signB;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [22:0] fracA;
    logic [22:0] fracB;
    logic        zeroA;
    logic        zeroB;
    logic        infA;
    logic        infB;
    logic        nanA;
    logic        nanB;

    assign signA = A[31];
    assign signB = B[31];
    assign expA  = A[30:23];
    assign expB  = B[30:23];
    assign fracA = A[22:0];
    assign fracB = B[22:0];

    // Subnormals (exp==0) are treated as signed zeros
    assign zeroA = (expA == 8'd0);
    assign zeroB = (expB == 8'd0);
    assign infA  = (expA == 8'hFF) && (fracA == 23'd0);
    assign infB  = (expB == 8'hFF) && (fracB == 23'd0);
    assign nanA  = (expA == 8'hFF) && (fracA != 23'd0);
    assign nanB  = (expB == 8'hFF) && (fracB != 23'd0);

    logic        aIsLarger;
    logic        signL;
    logic [7:0]  expL;
    logic [7:0]  expS;
    logic [23:0] mantL;
    logic [23:0] mantS;

    assign aIsLarger = ({expA, fracA} >= {expB, fracB});
    assign signL     = aIsLarger ? signA : signB;
    assign expL      = aIsLarger ? expA : expB;
    assign expS      = aIsLarger ? expB : expA;
    assign mantL     = {1'b1, (aIsLarger ? fracA : fracB)};
    assign mantS     = {1'b1, (aIsLarger ? fracB : fracA)};

    logic [7:0]  shiftAmt;
    logic [49:0] shiftWide;
    logic [23:0] mantSAligned;
    logic        guardS;
    logic        roundS;
    logic        stickyS;

    // Beyond 25 places the smaller operand can only affect the sticky bit
    always_comb begin
        shiftAmt  = expL - expS;
        shiftWide = {mantS, 26'd0} >> shiftAmt;
        if (shiftAmt >= 8'd26) begin
            mantSAligned = 24'd0;
            guardS       = 1'b0;
            roundS       = 1'b0;
            stickyS      = 1'b1;
        end else begin
            mantSAligned = shiftWide[49:26];
            guardS       = shiftWide[25];
            roundS       = shiftWide[24];
            stickyS      = |shiftWide[23:0];
        end
    end

    logic        effSub;
    logic [26:0] extL;
    logic [26:0] extS;
    logic [27:0] sumRaw;

    assign effSub = signA ^ signB;
    assign extL   = {mantL, 3'b000};
    assign extS   = {mantSAligned, guardS, roundS, stickyS};
    assign sumRaw = effSub ? {1'b0, extL - extS} : ({1'b0, extL} + {1'b0, extS});

    logic [4:0] lzCount;

    always_comb begin
        lzCount = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sumRaw[i]) begin
                lzCount = 5'(26 - i);
            end
        end
    end

    logic [26:0]       normSig;
    logic signed [9:0] expNorm;

    always_comb begin
        if (sumRaw[27]) begin
            normSig = {sumRaw[27:2], sumRaw[1] | sumRaw[0]};
            expNorm = $signed({2'b00, expL}) + 10'sd1;
        end else begin
            normSig = sumRaw[26:0] << lzCount;
            expNorm = $signed({2'b00, expL}) - $signed({5'd0, lzCount});
        end
    end

    logic              roundInc;
    logic [24:0]       mantRound;
    logic [22:0]       fracOut;
    logic signed [9:0] expFinal;

    // normSig[2:0] hold guard/round/sticky below the 24-bit significand
    assign roundInc  = RoundNearest & normSig[2] & (normSig[1] | normSig[0] | normSig[3]);
    assign mantRound = {1'b0, normSig[26:3]} + {24'd0, roundInc};
    assign fracOut   = mantRound[24] ? mantRound[23:1] : mantRound[22:0];
    assign expFinal  = expNorm + $signed({9'd0, mantRound[24]});

    logic [31:0] sumResult;

    always_comb begin
        sumResult = 32'h0;
        if (nanA || nanB || (infA && infB && (signA != signB))) begin
            sumResult = QuietNan;
        end else if (infA) begin
            sumResult = A;
        end else if (infB) begin
            sumResult = B;
        end else if (zeroA && zeroB) begin
            sumResult = {signA & signB, 31'd0};
        end else if (zeroA) begin
            sumResult = B;
        end else if (zeroB) begin
            sumResult = A;
        end else if (sumRaw == 28'd0) begin
            sumResult = 32'h0;
        end else if (expFinal >= 10'sd255) begin
            sumResult = {signL, 8'hFF, 23'd0};
        end else if (expFinal <= 10'sd0) begin
            sumResult = {signL, 31'd0};
        end else begin
            sumResult = {signL, expFinal[7:0], fracOut};
        end
    end

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        out_valid_d;
    logic        out_valid_q;

    assign result_d    = in_valid ? sumResult : result_q;
    assign out_valid_d = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_floating_point_adder.sv
// tb_floating_point_adder: directed vectors with hand-computed sums for floating_point_adder.
// Expected value of the rounding vector follows FPADD_ROUND_NEAREST_EN.
module tb_floating_point_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] result;

    int vectorCount;
    int missCount;

    floating_point_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and sample just after the capturing edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle();
        in_valid = 1'b0;
        A        = 32'h0;
        B        = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expResult, input logic expValid);
        vectorCount++;
        assert ((result === expResult) && (out_valid === expValid)) else begin
            missCount++;
            $error("[TB] FAIL %s result=%h valid=%b expected result=%h valid=%b",
                   tag, result, out_valid, expResult, expValid);
        end
    endtask

    task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expResult);
        applyStimulus(a, b);
        checkOutput(tag, expResult, 1'b1);
    endtask

    logic [31:0] roundExpected;

    initial begin
        vectorCount = 0;
        missCount   = 0;
`ifdef FPADD_ROUND_NEAREST_EN
        roundExpected = 32'h3F800001;
`else
        roundExpected = 32'h3F800000;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 32'h0;
        B        = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("reset_state", 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 32'h0, 1'b0);

        runVector("add_1p2", 32'h3F800000, 32'h40000000, 32'h40400000);
        applyIdle();
        checkOutput("idle_holds", 32'h40400000, 1'b0);

        runVector("sub_5m3", 32'h40A00000, 32'hC0400000, 32'h40000000);
        runVector("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
        runVector("neg_result", 32'h3F800000, 32'hC0000000, 32'hBF800000);
        runVector("carry_norm", 32'h3F800000, 32'h3F800000, 32'h40000000);
        runVector("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        runVector("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        runVector("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        runVector("neg_inf_pair", 32'hFF800000, 32'hFF800000, 32'hFF800000);
        runVector("inf_plus_fin", 32'h7F800000, 32'h3F800000, 32'h7F800000);
        runVector("round_grs", 32'h3F800000, 32'h33C00000, roundExpected);
        runVector("subnormal_ftz", 32'h00000001, 32'h00000001, 32'h00000000);
        runVector("negzero_pair", 32'h80000000, 32'h80000000, 32'h80000000);
        runVector("zero_plus_x", 32'h00000000, 32'hC0400000, 32'hC0400000);
        runVector("underflow", 32'h00C00000, 32'h80800000, 32'h00000000);

        // Four back-to-back operations, in_valid never drops
        runVector("b2b_0", 32'h3F800000, 32'h40000000, 32'h40400000);
        runVector("b2b_1", 32'h40A00000, 32'hC0400000, 32'h40000000);
        runVector("b2b_2", 32'h3F800000, 32'h3F800000, 32'h40000000);
        runVector("b2b_3", 32'h40400000, 32'hBF800000, 32'h40000000);

        // Reset asserted in the middle of a cycle with an op in flight
        A        = 32'h3F800000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_op", 32'h0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_release_idle", 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
